// File: rtl/spart_driver.sv
// Bus master for spart: programs the baud divisor after reset or on a br_cfg change, then echoes each byte.
// Read strobe follows rda sampled in POLL by one edge; waits indefinitely on rda/tbr (no internal buffering).
module spart_driver #(
  parameter int CLK_FREQ = 100_000_000
) (
  input  logic       clk,
  input  logic       rst,
  input  logic [1:0] br_cfg,
  input  logic       rda,
  input  logic       tbr,
  output logic       iocs,
  output logic       iorw,
  output logic [1:0] ioaddr,
  inout  wire  [7:0] databus,
  output logic [7:0] last_rx
);

  typedef enum logic [2:0] {
    S_INIT_LO  = 3'd0,
    S_INIT_HI  = 3'd1,
    S_POLL     = 3'd2,
    S_READ     = 3'd3,
    S_WAIT_TBR = 3'd4,
    S_WRITE    = 3'd5
  } state_t;

  state_t      r_state;
  state_t      w_next;
  logic        r_live;
  logic [1:0]  r_sync1;
  logic [1:0]  r_br_sync;
  logic [1:0]  r_cfg_q;
  logic [7:0]  r_rx_hold;
  logic [7:0]  r_last_rx;
  logic [7:0]  w_wdat;
  logic [15:0] w_div_new;
  logic [15:0] w_div_cur;

  function automatic logic [15:0] div_of(input logic [1:0] sel);
    int baud;
    case (sel)
      2'b00:   baud = 4800;
      2'b01:   baud = 9600;
      2'b10:   baud = 19200;
      default: baud = 38400;
    endcase
    return 16'(CLK_FREQ / (16 * baud) - 1);
  endfunction

  assign w_div_new = div_of(r_br_sync);
  assign w_div_cur = div_of(r_cfg_q);
  assign databus   = (iocs && !iorw) ? w_wdat : 8'bz;
  assign last_rx   = r_last_rx;

  // r_live holds the first INIT_LO strobe off until the cycle after reset release
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_state <= S_INIT_LO;
      r_live  <= 1'b0;
    end else begin
      r_state <= w_next;
      r_live  <= 1'b1;
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_sync1   <= 2'b00;
      r_br_sync <= 2'b00;
      r_cfg_q   <= 2'b00;
      r_rx_hold <= 8'h00;
      r_last_rx <= 8'h00;
    end else begin
      r_sync1   <= br_cfg;
      r_br_sync <= r_sync1;
      if (r_live && r_state == S_INIT_LO) r_cfg_q <= r_br_sync;
      if (r_live && r_state == S_READ) begin
        r_rx_hold <= databus;
        r_last_rx <= databus;
      end
    end
  end

  always_comb begin
    w_next = r_state;
    iocs   = 1'b0;
    iorw   = 1'b1;
    ioaddr = 2'b00;
    w_wdat = 8'h00;
    case (r_state)
      S_INIT_LO: begin
        if (r_live) begin
          iocs   = 1'b1;
          iorw   = 1'b0;
          ioaddr = 2'b10;
          w_wdat = w_div_new[7:0];
          w_next = S_INIT_HI;
        end
      end
      S_INIT_HI: begin
        iocs   = 1'b1;
        iorw   = 1'b0;
        ioaddr = 2'b11;
        w_wdat = w_div_cur[15:8];
        w_next = S_POLL;
      end
      S_POLL: begin
        if (r_br_sync != r_cfg_q) w_next = S_INIT_LO;
        else if (rda)             w_next = S_READ;
      end
      S_READ: begin
        iocs   = 1'b1;
        w_next = S_WAIT_TBR;
      end
      S_WAIT_TBR: begin
        if (tbr) w_next = S_WRITE;
      end
      S_WRITE: begin
        iocs   = 1'b1;
        iorw   = 1'b0;
        w_wdat = r_rx_hold;
        w_next = S_POLL;
      end
      default: w_next = S_INIT_LO;
    endcase
  end

endmodule

// File: tb/tb_spart_driver.sv
// Bench for spart_driver: a spart stand-in feeds bytes from a queue and logs every bus strobe.
module tb_spart_driver;
  logic       clk = 1'b0;
  logic       rst;
  logic [1:0] br_cfg;
  logic       rda = 1'b0;
  logic       tbr;
  logic       iocs;
  logic       iorw;
  logic [1:0] ioaddr;
  wire  [7:0] databus;
  logic [7:0] last_rx;

  logic [7:0]  rd_dat = 8'h00;
  logic [7:0]  rx_q[$];
  logic [10:0] log_q[$];   // {rw, addr, data}
  int          zviol = 0;
  int          checks = 0;
  int          errors = 0;

  // Divisor values at 100 MHz, taken directly from the baud table
  logic [15:0] div_tab [4] = '{16'h0515, 16'h028A, 16'h0144, 16'h00A1};

  spart_driver dut (
    .clk(clk), .rst(rst), .br_cfg(br_cfg), .rda(rda), .tbr(tbr),
    .iocs(iocs), .iorw(iorw), .ioaddr(ioaddr), .databus(databus), .last_rx(last_rx)
  );

  always #5 clk = ~clk;

  assign databus = (iocs && iorw) ? rd_dat : 8'bz;

  // spart stand-in: serves reads from rx_q, records every strobe mid-cycle
  always @(negedge clk) begin
    if (iocs) begin
      if (iorw) begin
        if (rx_q.size() > 0) rd_dat = rx_q.pop_front();
        else                 rd_dat = 8'hEE;
        log_q.push_back({1'b1, ioaddr, rd_dat});
      end else begin
        log_q.push_back({1'b0, ioaddr, databus});
      end
    end else if (databus !== 8'bz) begin
      zviol++;
    end
    rda = (rx_q.size() != 0);
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic cyc(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  function automatic logic [10:0] wr_ent(input logic [1:0] a, input logic [7:0] d);
    return {1'b0, a, d};
  endfunction

  function automatic logic [10:0] rd_ent(input logic [7:0] d);
    return {1'b1, 2'b00, d};
  endfunction

  // last divisor pair on the bus must be the one for sel, with no reads among the programming
  task automatic chk_prog(input string tag, input logic [1:0] sel);
    logic [15:0] dv;
    int          n;
    int          nrd;
    dv  = div_tab[sel];
    n   = log_q.size();
    nrd = 0;
    foreach (log_q[i]) if (log_q[i][10]) nrd++;
    chk({tag, "_reads"}, nrd, 0);
    chk({tag, "_npairs_even"}, n % 2, 0);
    if (n >= 2) begin
      chk({tag, "_lo"}, log_q[n-2], wr_ent(2'b10, dv[7:0]));
      chk({tag, "_hi"}, log_q[n-1], wr_ent(2'b11, dv[15:8]));
    end else begin
      chk({tag, "_count"}, n, 2);
    end
  endtask

  initial begin
    logic [7:0] exp_q[$];
    logic [7:0] wr_seen[$];
    logic       found;
    logic [7:0] b;
    int         pushed;

    // Reset state
    rst = 1'b0; br_cfg = 2'b01; tbr = 1'b0;
    cyc(3);
    chk("rst_iocs", iocs, 1'b0);
    chk("rst_iorw", iorw, 1'b1);
    chk("rst_ioaddr", ioaddr, 2'b00);
    chk("rst_bus_z", databus === 8'bz, 1'b1);
    chk("rst_last_rx", last_rx, 8'h00);

    // Divisor programming after release
    log_q.delete();
    rst = 1'b1;
    cyc(1);
    chk("init_c1_iocs", iocs, 1'b1);
    chk("init_c1_iorw", iorw, 1'b0);
    chk("init_c1_addr", ioaddr, 2'b10);
    cyc(1);
    chk("init_c2_iocs", iocs, 1'b1);
    chk("init_c2_addr", ioaddr, 2'b11);
    cyc(10);
    chk_prog("init", 2'b01);
    chk("init_idle_iocs", iocs, 1'b0);
    chk("init_idle_z", databus === 8'bz, 1'b1);

    // Single echo with exact latency
    log_q.delete();
    tbr = 1'b1;
    rx_q.push_back(8'h41);
    cyc(1);
    chk("echo_rd_iocs", iocs, 1'b1);
    chk("echo_rd_iorw", iorw, 1'b1);
    chk("echo_rd_addr", ioaddr, 2'b00);
    cyc(1);
    chk("echo_last_rx", last_rx, 8'h41);
    chk("echo_gap_iocs", iocs, 1'b0);
    cyc(1);
    chk("echo_wr_iocs", iocs, 1'b1);
    chk("echo_wr_iorw", iorw, 1'b0);
    chk("echo_wr_addr", ioaddr, 2'b00);
    chk("echo_wr_data", databus, 8'h41);
    cyc(1);
    chk("echo_back_poll", iocs, 1'b0);
    chk("echo_log_n", log_q.size(), 2);

    // Transmitter busy: write held off until tbr
    log_q.delete();
    tbr = 1'b0;
    rx_q.push_back(8'h5A);
    cyc(22);
    chk("tbr_wait_n", log_q.size(), 1);
    if (log_q.size() >= 1) chk("tbr_wait_rd", log_q[0], rd_ent(8'h5A));
    chk("tbr_wait_iocs", iocs, 1'b0);
    chk("tbr_wait_z", databus === 8'bz, 1'b1);
    chk("tbr_last_rx", last_rx, 8'h5A);
    tbr = 1'b1;
    cyc(4);
    chk("tbr_release_n", log_q.size(), 2);
    if (log_q.size() >= 2) chk("tbr_release_wr", log_q[1], wr_ent(2'b00, 8'h5A));

    // Baud change arriving together with rda: reprogram first
    log_q.delete();
    br_cfg = 2'b11;
    @(posedge clk);
    @(posedge clk);
    #1;
    rx_q.push_back(8'h6C);
    cyc(12);
    chk("cfg_n", log_q.size(), 4);
    if (log_q.size() == 4) begin
      chk("cfg_lo", log_q[0], wr_ent(2'b10, 8'hA1));
      chk("cfg_hi", log_q[1], wr_ent(2'b11, 8'h00));
      chk("cfg_rd", log_q[2], rd_ent(8'h6C));
      chk("cfg_wr", log_q[3], wr_ent(2'b00, 8'h6C));
    end

    // Reset in the middle of a write
    rx_q.push_back(8'h33);
    found = 1'b0;
    for (int i = 0; i < 20 && !found; i++) begin
      @(posedge clk);
      #1;
      if (iocs && !iorw && ioaddr == 2'b00) found = 1'b1;
    end
    chk("rstwr_seen", found, 1'b1);
    chk("rstwr_data", databus, 8'h33);
    #2 rst = 1'b0;
    #1;
    chk("rstwr_iocs", iocs, 1'b0);
    chk("rstwr_z", databus === 8'bz, 1'b1);
    chk("rstwr_last_rx", last_rx, 8'h00);
    cyc(1);
    log_q.delete();
    rst = 1'b1;
    cyc(12);
    chk_prog("rstwr_reprog", 2'b11);

    // Back-to-back stream with rda held high
    log_q.delete();
    rx_q.push_back(8'h00);
    rx_q.push_back(8'hFF);
    rx_q.push_back(8'h7E);
    cyc(20);
    chk("stream_n", log_q.size(), 6);
    if (log_q.size() == 6) begin
      chk("stream_r0", log_q[0], rd_ent(8'h00));
      chk("stream_w0", log_q[1], wr_ent(2'b00, 8'h00));
      chk("stream_r1", log_q[2], rd_ent(8'hFF));
      chk("stream_w1", log_q[3], wr_ent(2'b00, 8'hFF));
      chk("stream_r2", log_q[4], rd_ent(8'h7E));
      chk("stream_w2", log_q[5], wr_ent(2'b00, 8'h7E));
    end

    // Random bytes and random tbr: echoes must reproduce the input stream in order
    log_q.delete();
    pushed = 0;
    for (int c = 0; c < 400; c++) begin
      tbr = 1'($urandom_range(0, 1));
      if (pushed < 12 && $urandom_range(0, 3) == 0) begin
        b = 8'($urandom);
        rx_q.push_back(b);
        exp_q.push_back(b);
        pushed++;
      end
      cyc(1);
    end
    tbr = 1'b1;
    cyc(20);
    foreach (log_q[i]) if (!log_q[i][10] && log_q[i][9:8] == 2'b00) wr_seen.push_back(log_q[i][7:0]);
    chk("rand_wr_count", wr_seen.size(), exp_q.size());
    for (int i = 0; i < exp_q.size() && i < wr_seen.size(); i++)
      chk($sformatf("rand_wr%0d", i), wr_seen[i], exp_q[i]);
    if (exp_q.size() > 0) chk("rand_last_rx", last_rx, exp_q[exp_q.size()-1]);

    chk("bus_released_when_idle", zviol, 0);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
